// File: rtl/mem_ops_pkg.sv
// Shared definitions for the MEM-stage / data-cache sequencer.
// Holds the memory op codes, access classification helpers, the controller
// state enum and the packed record of a captured request.
package mem_ops_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [OP_W-1:0] OP_NOP = 4'd0;
    localparam logic [OP_W-1:0] OP_LB  = 4'd1;
    localparam logic [OP_W-1:0] OP_LH  = 4'd2;
    localparam logic [OP_W-1:0] OP_LW  = 4'd3;
    localparam logic [OP_W-1:0] OP_LBU = 4'd4;
    localparam logic [OP_W-1:0] OP_LHU = 4'd5;
    localparam logic [OP_W-1:0] OP_SB  = 4'd6;
    localparam logic [OP_W-1:0] OP_SH  = 4'd7;
    localparam logic [OP_W-1:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    // Request as held stable on the cache bus while BUSY
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic size_e access_size(input logic [OP_W-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    // Only real memory ops can be misaligned; NOP and unknown codes never are
    function automatic logic is_misaligned(input logic [OP_W-1:0] op,
                                           input logic [1:0]      ofs);
        if (!(is_load(op) || is_store(op))) begin
            return 1'b0;
        end
        case (access_size(op))
            SZ_HALF: return ofs[0];
            SZ_WORD: return (ofs != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-cache request/response bus.
// master: controller side (drives request), slave: cache side (drives ready/rdata).
interface mem_access_ctrl_if;
    import mem_ops_pkg::*;

    logic            mem_req;
    logic            mem_we;
    logic [BE_W-1:0] mem_be;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_access_ctrl_load_align.sv
// load_align: combinational shift-and-extend of a cache word into a load result.
// Ports: op (load op code), offset (addr[1:0]), word (raw cache word),
//        result (shifted, sign/zero-extended value).
module load_align
    import mem_ops_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] result
);

    logic [15:0] lane;

    // Bring the addressed byte/half down to bit 0, then extend
    always_comb begin
        lane   = 16'(word >> {offset, 3'b000});
        result = word;
        case (op)
            OP_LB:   result = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  result = {24'd0, lane[7:0]};
            OP_LH:   result = {{16{lane[15]}}, lane[15:0]};
            OP_LHU:  result = {16'd0, lane[15:0]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one load/store from the MEM stage to the data cache.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/op/addr/wdata    MEM-stage request, held while stall=1
//   stall, misalign            combinational pipeline freeze / alignment fault
//   rsp_valid, rsp_rdata       registered load result (one-cycle valid)
//   cache                      cache bus (master side)
//   cnt_clear                  synchronous clear of both counters
//   access_cnt, miss_cnt       accepted accesses / accesses missing on first BUSY cycle
module mem_access_ctrl
    import mem_ops_pkg::*;
#(
    parameter int unsigned CNT_W = 32
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [OP_W-1:0]     req_op,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                stall,
    output logic                misalign,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    mem_access_ctrl_if.master   cache,
    input  logic                cnt_clear,
    output logic [CNT_W-1:0]    access_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);

    state_e          state_q;
    state_e          state_d;
    mem_req_t        req_q;
    mem_req_t        req_d;
    logic            first_q;
    logic            mem_req_q;
    logic            go;
    logic            misaligned;
    logic            load_done;
    logic            miss_inc;
    logic [XLEN-1:0] load_val;

    // Store lane placement and request capture value
    always_comb begin
        req_d       = '0;
        req_d.op    = req_op;
        req_d.we    = is_store(req_op);
        req_d.addr  = req_addr;
        req_d.be    = 4'b1111;
        req_d.wdata = req_wdata;
        case (req_op)
            OP_SB: begin
                req_d.be    = 4'(4'b0001 << req_addr[1:0]);
                req_d.wdata = {4{req_wdata[7:0]}};
            end
            OP_SH: begin
                req_d.be    = req_addr[1] ? 4'b1100 : 4'b0011;
                req_d.wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, accept decision and combinational pipeline outputs.
    // go/misalign are gated by rst_n so both read 0 while reset is held.
    always_comb begin
        state_d    = state_q;
        go         = 1'b0;
        stall      = 1'b0;
        misalign   = 1'b0;
        misaligned = is_misaligned(req_op, req_addr[1:0]);
        case (state_q)
            IDLE: begin
                go       = rst_n & req_valid & (is_load(req_op) | is_store(req_op)) & ~misaligned;
                misalign = rst_n & req_valid & misaligned;
                stall    = go;
                if (go) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cache.mem_ready) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign load_done = (state_q == BUSY) && cache.mem_ready && is_load(req_q.op);
    assign miss_inc  = (state_q == BUSY) && first_q && !cache.mem_ready;

    load_align u_load_align (
        .op     (req_q.op),
        .offset (req_q.addr[1:0]),
        .word   (cache.mem_rdata),
        .result (load_val)
    );

    // Request hold, response capture and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= '0;
            first_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            access_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            mem_req_q <= (state_d == BUSY);
            rsp_valid <= load_done;
            // first_q marks exactly the first BUSY cycle of each access
            first_q   <= go;
            if (go) begin
                req_q <= req_d;
            end
            if (load_done) begin
                rsp_rdata <= load_val;
            end
            if (cnt_clear) begin
                access_cnt <= '0;
            end else if (go) begin
                access_cnt <= access_cnt + CNT_W'(1);
            end
            if (cnt_clear) begin
                miss_cnt <= '0;
            end else if (miss_inc) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

    assign cache.mem_req   = mem_req_q;
    assign cache.mem_we    = req_q.we;
    assign cache.mem_be    = req_q.be;
    assign cache.mem_addr  = {req_q.addr[31:2], 2'b00};
    assign cache.mem_wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, hand-written
// corner sequences and randomized accesses against a behavioural model.
module tb_mem_access_ctrl;
    import mem_ops_pkg::*;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MOD = 2 ** CNT_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic [3:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic              misalign;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              cnt_clear;
    logic [CNT_W-1:0]  access_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .misalign   (misalign),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .cache      (bus.master),
        .cnt_clear  (cnt_clear),
        .access_cnt (access_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state
    int unsigned m_acc  = 0;
    int unsigned m_miss = 0;
    logic [31:0] m_rdata = 32'd0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        int          lat;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit m_is_load(input logic [3:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic bit m_is_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Expected load value from arithmetic on the byte/half value
    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] word);
        longint unsigned v;
        longint unsigned b;
        longint unsigned h;
        v = {32'd0, word} >> (8 * (addr % 4));
        b = v % 256;
        h = v % 65536;
        case (op)
            OP_LB:   return (b >= 128) ? (32'(b) | 32'hFFFF_FF00) : 32'(b);
            OP_LBU:  return 32'(b);
            OP_LH:   return (h >= 32768) ? (32'(h) | 32'hFFFF_0000) : 32'(h);
            OP_LHU:  return 32'(h);
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] addr);
        case (op)
            OP_SB:   return 4'(1 << (addr % 4));
            OP_SH:   return ((addr % 4) == 2) ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
        case (op)
            OP_SB:   return (d % 256) * 32'h0101_0101;
            OP_SH:   return (d % 65536) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    // Runs one access starting in IDLE at posedge+1; returns at posedge+1 after DONE
    task automatic do_access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] word, input int lat,
                             input bit clr, input logic [31:0] exp_rdata,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        int stalls;
        int busy;
        bit done;
        bit ld;
        stalls = 0;
        busy   = 0;
        done   = 1'b0;
        ld     = m_is_load(op);

        req_valid     = 1'b1;
        req_op        = op;
        req_addr      = addr;
        req_wdata     = wdata;
        cnt_clear     = clr;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
        #2;
        check({tag, " accept stall"}, 32'(stall), 32'd1);
        check({tag, " accept misalign"}, 32'(misalign), 32'd0);
        if (stall) stalls++;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        if (clr) begin
            m_acc  = 0;
            m_miss = 0;
        end else begin
            m_acc = (m_acc + 1) % CNT_MOD;
        end

        while (!done && busy < 40) begin
            check({tag, " busy mem_req"}, 32'(bus.mem_req), 32'd1);
            check({tag, " busy mem_we"}, 32'(bus.mem_we), 32'(m_is_store(op)));
            check({tag, " busy mem_be"}, 32'(bus.mem_be), 32'(exp_be));
            check({tag, " busy mem_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
            if (m_is_store(op)) check({tag, " busy mem_wdata"}, bus.mem_wdata, exp_wdata);
            check({tag, " busy rsp_valid"}, 32'(rsp_valid), 32'd0);
            if (busy == 0 && lat > 0) m_miss = (m_miss + 1) % CNT_MOD;
            if (busy == lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = word;
                done          = 1'b1;
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
            end
            #2;
            if (stall) stalls++;
            @(posedge clk); #1;
            busy++;
        end
        if (!done) check({tag, " busy timeout"}, 32'd1, 32'd0);
        bus.mem_ready = 1'b0;

        #2;
        check({tag, " done stall"}, 32'(stall), 32'd0);
        check({tag, " done mem_req"}, 32'(bus.mem_req), 32'd0);
        check({tag, " done rsp_valid"}, 32'(rsp_valid), 32'(ld));
        if (ld) m_rdata = exp_rdata;
        check({tag, " rsp_rdata"}, rsp_rdata, m_rdata);
        check({tag, " access_cnt"}, 32'(access_cnt), m_acc);
        check({tag, " miss_cnt"}, 32'(miss_cnt), m_miss);
        check({tag, " stall cycles"}, 32'(stalls), 32'(lat + 2));
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = OP_NOP;
        check({tag, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " idle rsp_rdata hold"}, rsp_rdata, m_rdata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[16];
        logic [3:0]  ops[8];
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] d;
        logic [31:0] w;

        vecs[0]  = '{OP_LB,  32'h1003, 32'h0,         32'h80FF_1234, 0, 32'hFFFF_FF80, 4'hF, 32'h0};
        vecs[1]  = '{OP_SH,  32'h2002, 32'h0000_BEEF, 32'h1111_2222, 4, 32'h0,         4'hC, 32'hBEEF_BEEF};
        vecs[2]  = '{OP_LBU, 32'h0100, 32'h0,         32'h8765_4321, 0, 32'h0000_0021, 4'hF, 32'h0};
        vecs[3]  = '{OP_LBU, 32'h0101, 32'h0,         32'h8765_4321, 1, 32'h0000_0043, 4'hF, 32'h0};
        vecs[4]  = '{OP_LBU, 32'h0102, 32'h0,         32'h8765_4321, 0, 32'h0000_0065, 4'hF, 32'h0};
        vecs[5]  = '{OP_LBU, 32'h0103, 32'h0,         32'h8765_4321, 2, 32'h0000_0087, 4'hF, 32'h0};
        vecs[6]  = '{OP_LH,  32'h0100, 32'h0,         32'h8765_4321, 0, 32'h0000_4321, 4'hF, 32'h0};
        vecs[7]  = '{OP_LH,  32'h0102, 32'h0,         32'h8765_4321, 0, 32'hFFFF_8765, 4'hF, 32'h0};
        vecs[8]  = '{OP_LHU, 32'h0100, 32'h0,         32'h8765_4321, 1, 32'h0000_4321, 4'hF, 32'h0};
        vecs[9]  = '{OP_LHU, 32'h0102, 32'h0,         32'h8765_4321, 0, 32'h0000_8765, 4'hF, 32'h0};
        vecs[10] = '{OP_LW,  32'h0100, 32'h0,         32'h8765_4321, 0, 32'h8765_4321, 4'hF, 32'h0};
        vecs[11] = '{OP_LB,  32'h0103, 32'h0,         32'h8765_4321, 0, 32'hFFFF_FF87, 4'hF, 32'h0};
        vecs[12] = '{OP_SB,  32'h0041, 32'h1234_56AB, 32'h0,         2, 32'h0,         4'h2, 32'hABAB_ABAB};
        vecs[13] = '{OP_SW,  32'h0044, 32'hCAFE_F00D, 32'h0,         1, 32'h0,         4'hF, 32'hCAFE_F00D};
        vecs[14] = '{OP_SH,  32'h0048, 32'h1234_5678, 32'h0,         0, 32'h0,         4'h3, 32'h5678_5678};
        vecs[15] = '{OP_SB,  32'h004B, 32'h0000_00C3, 32'h0,         0, 32'h0,         4'h8, 32'hC3C3_C3C3};

        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

        // Reset values
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_op        = OP_NOP;
        req_addr      = 32'd0;
        req_wdata     = 32'd0;
        cnt_clear     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        #2;
        check("reset stall", 32'(stall), 32'd0);
        check("reset misalign", 32'(misalign), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset mem_req", 32'(bus.mem_req), 32'd0);
        check("reset mem_we", 32'(bus.mem_we), 32'd0);
        check("reset mem_be", 32'(bus.mem_be), 32'd0);
        check("reset mem_addr", bus.mem_addr, 32'd0);
        check("reset mem_wdata", bus.mem_wdata, 32'd0);
        check("reset access_cnt", 32'(access_cnt), 32'd0);
        check("reset miss_cnt", 32'(miss_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            do_access($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                      vecs[i].word, vecs[i].lat, 1'b0, vecs[i].exp_rdata,
                      vecs[i].exp_be, vecs[i].exp_wdata);
        end

        // Misaligned word load held for several cycles: no access, no stall
        req_valid = 1'b1;
        req_op    = OP_LW;
        req_addr  = 32'h3001;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("misalign LW flag", 32'(misalign), 32'd1);
            check("misalign LW stall", 32'(stall), 32'd0);
            check("misalign LW mem_req", 32'(bus.mem_req), 32'd0);
            @(posedge clk); #1;
        end
        req_op   = OP_LH;
        req_addr = 32'h3003;
        #2;
        check("misalign LH flag", 32'(misalign), 32'd1);
        req_op = OP_NOP;
        #1;
        check("nop odd addr misalign", 32'(misalign), 32'd0);
        check("nop stall", 32'(stall), 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("misalign access_cnt", 32'(access_cnt), m_acc);
        check("misalign miss_cnt", 32'(miss_cnt), m_miss);
        check("misalign mem_req", 32'(bus.mem_req), 32'd0);

        // Reset in the middle of BUSY
        req_valid     = 1'b1;
        req_op        = OP_LW;
        req_addr      = 32'h0500;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-reset mem_req", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-busy reset mem_req", 32'(bus.mem_req), 32'd0);
        check("mid-busy reset stall", 32'(stall), 32'd0);
        check("mid-busy reset access_cnt", 32'(access_cnt), 32'd0);
        check("mid-busy reset miss_cnt", 32'(miss_cnt), 32'd0);
        check("mid-busy reset rsp_rdata", rsp_rdata, 32'd0);
        m_acc     = 0;
        m_miss    = 0;
        m_rdata   = 32'd0;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_access("post-reset LW", OP_LW, 32'h0504, 32'd0, 32'hA5A5_1234, 1, 1'b0,
                  32'hA5A5_1234, 4'hF, 32'd0);

        // Clear together with an accept, then wrap the access counter
        do_access("clear+accept", OP_LHU, 32'h0602, 32'd0, 32'hFACE_0000, 2, 1'b1,
                  32'h0000_FACE, 4'hF, 32'd0);
        check("clear access_cnt", 32'(access_cnt), 32'd0);
        check("clear miss_cnt", 32'(miss_cnt), 32'd1);
        for (int i = 0; i < int'(CNT_MOD); i++) begin
            do_access("wrap", OP_SW, 32'h0700, 32'(i), 32'd0, 0, 1'b0, 32'd0, 4'hF, 32'(i));
        end
        check("wrap access_cnt", 32'(access_cnt), 32'd0);

        // Randomized accesses against the model
        for (int i = 0; i < 60; i++) begin
            op   = ops[$urandom_range(0, 7)];
            addr = $urandom;
            d    = $urandom;
            w    = $urandom;
            if (op inside {OP_LH, OP_LHU, OP_SH}) addr = addr & 32'hFFFF_FFFE;
            if (op inside {OP_LW, OP_SW}) addr = addr & 32'hFFFF_FFFC;
            do_access($sformatf("rand%0d", i), op, addr, d, w, int'($urandom_range(0, 3)),
                      ($urandom_range(0, 9) == 0), m_load(op, addr, w), m_be(op, addr),
                      m_wdata(op, d));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing controller between the MEM pipeline stage and the data cache. Accepts one load/store per instruction and checks alignment. Issues a word-aligned, byte-enabled request to the cache and holds the pipeline stalled until the cache answers. Returns the load value, shifted to the addressed byte/half and sign/zero-extended, and keeps access and miss counters for the cache lab.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM stage holds a memory op (held stable while stall=1)
- req_op  in  4  op code from mem_ops_pkg: OP_NOP, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, value in low bits
- stall  out  1  freeze pipeline
- misalign  out  1  misaligned access flag (level)
- rsp_valid  out  1  load result valid (one cycle)
- rsp_rdata  out  32  extended load result
- mem_req  out  1  cache request, held until mem_ready
- mem_we  out  1  1 = store
- mem_be  out  4  byte enables
- mem_addr  out  32  {req_addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  cache completes request this cycle
- mem_rdata  in  32  cache read word, valid with mem_ready
- cnt_clear  in  1  synchronous clear of both counters
- access_cnt  out  CNT_W  accepted accesses
- miss_cnt  out  CNT_W  accesses whose first BUSY cycle had mem_ready=0

## Operation
- **FSM states:**
  - **IDLE:** `go` = req_valid & op≠NOP & aligned. On `go`, capture op, addr, be, shifted wdata and move to BUSY.
  - **BUSY:** mem_req=1 with all mem_* outputs from registers, stable. On mem_ready, move to DONE and register the extended load data.
  - **DONE:** move to IDLE unconditionally; request inputs are ignored.
- **Alignment:**
  - Halfword ops are misaligned if addr[0]=1.
  - Word ops are misaligned if addr[1:0]≠0.
  - misalign = IDLE & req_valid & misaligned. No memory access and no stall; the trap logic flushes.
- **Store lanes:**
  - SB: be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{d[15:0]}}.
  - SW: be=4'b1111, wdata=d.
- **Loads:** mem_we=0, be=4'b1111. Take w = mem_rdata>>(8*addr[1:0]).
  - LB: sign-extend w[7:0].
  - LBU: zero-extend w[7:0].
  - LH: sign-extend w[15:0].
  - LHU: zero-extend w[15:0].
  - LW: mem_rdata unchanged.
- **Response:**
  - rsp_valid=1 in DONE for loads only.
  - rsp_rdata holds its last value until the next load completes.
  - rsp_rdata is 0 after reset.
- **Counters:**
  - access_cnt increments on IDLE→BUSY.
  - miss_cnt increments once per access, on the first BUSY cycle if mem_ready=0.
  - Both wrap modulo 2^CNT_W.
  - cnt_clear has priority over a same-cycle increment.

## Timing
- stall = (IDLE & go) | BUSY. stall is 0 in DONE, so the pipeline advances at the end of DONE.
- Hit path:
  - Cycle T: accept, stall=1.
  - Cycle T+1: BUSY with mem_ready=1, stall=1.
  - Cycle T+2: DONE, rsp_valid=1, stall=0.
  - Total 2 stall cycles.
- Each cycle of mem_ready=0 in BUSY adds one stall cycle. There is no timeout.
- mem_ready outside BUSY is ignored.
- Back-to-back accesses: the next op is accepted in the cycle after DONE, so there is one IDLE gap minimum.
- Reset values (asynchronous on rst_n=0, including mid-BUSY):
  - state=IDLE.
  - stall, misalign, rsp_valid, mem_req, mem_we = 0.
  - mem_be=0, mem_addr=0, mem_wdata=0, rsp_rdata=0.
  - Counters=0.
- mem_req drops in the reset cycle. The cache is required to tolerate an abandoned request.
- stall and misalign are combinational from inputs and state. All other outputs are registered.

## Structure
- Package mem_ops_pkg holds:
  - the 4-bit op codes,
  - helper functions is_load, is_store, access size,
  - the state enum IDLE/BUSY/DONE.
- Sub-module load_align: purely combinational shift-and-extend (op, addr[1:0], word → 32-bit result), instantiated once.
- Store lane logic, FSM and counters stay in mem_access_ctrl.

## Test plan
- **LB hit:** LB, addr 0x1003, mem_rdata 0x80FF_1234 with mem_ready in the first BUSY cycle → rsp_rdata 0xFFFF_FF80, stall high for exactly 2 cycles, access_cnt=1, miss_cnt=0.
- **SH miss:** SH, addr 0x2002, wdata 0x0000_BEEF, mem_ready after 5 BUSY cycles → mem_be 4'b1100, mem_wdata 0xBEEF_BEEF, mem_we=1, stall 6 cycles, no rsp_valid, miss_cnt=1.
- **Misalign:** LW at 0x3001 → misalign=1, stall=0, mem_req never asserted, counters unchanged.
- **All loads, all offsets:** LBU/LH/LHU/LW at each offset 0–3 (aligned ones only), word 0x8765_4321 → e.g. LHU@2 = 0x0000_8765, LH@2 = 0xFFFF_8765, LBU@1 = 0x0000_0043.
- **Reset mid-BUSY:** assert rst_n=0 mid-BUSY → mem_req and stall drop the same cycle, counters 0. The next request after release completes normally.
- **Counter clear and wrap:** cnt_clear together with an accept → counter reads 0. Counter preloaded at 2^CNT_W-1 plus one access → counter reads 0.
